// File: rtl/mem_unit_param.sv
// LC-3 memory unit: MAR/MDR, MDR source mux and a single-array RAM shared between
// CPU accesses (mem_en/mem_ready handshake with programmable wait) and a debug port.
module mem_unit_param #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int MEM_AW      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              sel_mdr,
  input  logic              mem_en,
  input  logic              mem_we,
  output logic [DATA_W-1:0] mdr_out,
  output logic              mem_ready,
  output logic              addr_err,
  output logic              busy,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [MEM_AW-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack
);

  localparam int DEPTH      = 1 << MEM_AW;
  localparam int CNT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int CNT_LAST_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_DBG} state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic [ADDR_W-1:0] r_a_addr;
  logic [DATA_W-1:0] r_a_data;
  logic              r_a_we;
  logic              r_mem_ready;
  logic              r_addr_err;
  logic              r_dbg_ack;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_start;
  logic              w_done;
  logic              w_dbg;
  logic              w_busy;
  logic              w_oor;
  logic              w_ram_we;
  logic [MEM_AW-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (mem_en)       w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
        else if (dbg_req) w_next = S_DBG;
      end
      S_WAIT:  if (r_cnt == CNT_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_DBG:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_start = (r_state == S_IDLE) && mem_en;
    w_done  = (r_state == S_DONE);
    w_dbg   = (r_state == S_DBG);
    w_busy  = (r_state != S_IDLE);
  end

  // Any set bit above the implemented depth is out of range; the low bits never alias.
  assign w_oor       = (r_a_addr >> MEM_AW) != '0;
  assign w_ram_addr  = w_dbg ? dbg_addr : r_a_addr[MEM_AW-1:0];
  assign w_ram_wdata = w_dbg ? dbg_wdata : r_a_data;
  assign w_ram_we    = (w_done && r_a_we && !w_oor) || (w_dbg && dbg_we);

  // NOTE: the RAM array carries no reset; its contents survive reset like a real memory.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_mar       <= '0;
      r_mdr       <= '0;
      r_rdata     <= '0;
      r_dbg_rdata <= '0;
      r_a_addr    <= '0;
      r_a_data    <= '0;
      r_a_we      <= 1'b0;
      r_mem_ready <= 1'b0;
      r_addr_err  <= 1'b0;
      r_dbg_ack   <= 1'b0;
    end else begin
      r_cnt       <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;
      r_mem_ready <= w_done;
      r_addr_err  <= w_done && w_oor;
      r_dbg_ack   <= w_dbg;
      if (ld_mar) r_mar <= bus_in;
      if (ld_mdr) r_mdr <= sel_mdr ? r_rdata : bus_in;
      // The snapshot isolates the access in flight from later MAR/MDR loads.
      if (w_start) begin
        r_a_addr <= r_mar;
        r_a_data <= r_mdr;
        r_a_we   <= mem_we;
      end
      if (w_done && !r_a_we) r_rdata <= w_oor ? '0 : r_mem[w_ram_addr];
      if (w_dbg && !dbg_we)  r_dbg_rdata <= r_mem[w_ram_addr];
    end
  end

  assign mdr_out   = r_mdr;
  assign mem_ready = r_mem_ready;
  assign addr_err  = r_addr_err;
  assign busy      = w_busy;
  assign dbg_rdata = r_dbg_rdata;
  assign dbg_ack   = r_dbg_ack;

endmodule

// File: tb/tb_mem_unit_param.sv
// Directed bench for mem_unit_param: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance
// share the stimulus; expected values are hand-computed constants.
module tb_mem_unit_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] bus_in = '0;
  logic        ld_mar = 1'b0, ld_mdr = 1'b0, sel_mdr = 1'b0;
  logic        mem_en = 1'b0, mem_we = 1'b0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [11:0] dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;

  logic [15:0] mdr_out, dbg_rdata, mdr_out0, dbg_rdata0;
  logic        mem_ready, addr_err, busy, dbg_ack;
  logic        mem_ready0, addr_err0, busy0, dbg_ack0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_unit_param #(.DATA_W(16), .ADDR_W(16), .MEM_AW(12), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .sel_mdr(sel_mdr), .mem_en(mem_en), .mem_we(mem_we), .mdr_out(mdr_out),
    .mem_ready(mem_ready), .addr_err(addr_err), .busy(busy), .dbg_req(dbg_req),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack)
  );

  mem_unit_param #(.DATA_W(16), .ADDR_W(16), .MEM_AW(12), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .sel_mdr(sel_mdr), .mem_en(mem_en), .mem_we(mem_we), .mdr_out(mdr_out0),
    .mem_ready(mem_ready0), .addr_err(addr_err0), .busy(busy0), .dbg_req(dbg_req),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata0), .dbg_ack(dbg_ack0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mar(input logic [15:0] v);
    bus_in = v; ld_mar = 1'b1;
    tick();
    ld_mar = 1'b0;
  endtask

  task automatic load_mdr_bus(input logic [15:0] v);
    bus_in = v; ld_mdr = 1'b1; sel_mdr = 1'b0;
    tick();
    ld_mdr = 1'b0;
  endtask

  task automatic load_mdr_rdata();
    ld_mdr = 1'b1; sel_mdr = 1'b1;
    tick();
    ld_mdr = 1'b0; sel_mdr = 1'b0;
  endtask

  // Returns ticks after the mem_en edge until mem_ready (20 = timed out), for both instances.
  // Leaves the bench in the cycle where dut's mem_ready is high.
  task automatic cpu_access(input logic we, output int lat, output int lat0, output logic err);
    lat = 0; lat0 = 0; err = 1'b0;
    mem_en = 1'b1; mem_we = we;
    tick();
    mem_en = 1'b0; mem_we = 1'b0;
    do begin
      tick();
      lat++;
      if (mem_ready0 && lat0 == 0) lat0 = lat;
    end while (!mem_ready && lat < 20);
    err = addr_err;
  endtask

  // Holds dbg_req until dbg_ack; returns ticks waited (20 = timed out).
  task automatic dbg_access(input logic we, input logic [11:0] a, input logic [15:0] d,
                            output int n);
    n = 0;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    do begin
      tick();
      n++;
    end while (!dbg_ack && n < 20);
    dbg_req = 1'b0; dbg_we = 1'b0;
  endtask

  initial begin
    int   lat, lat0, n, pulses;
    logic err;

    // Reset state
    #12;
    check("rst_mdr", mdr_out, 16'h0);
    check("rst_ready", mem_ready, 1'b0);
    check("rst_err", addr_err, 1'b0);
    check("rst_ack", dbg_ack, 1'b0);
    check("rst_dbg_rdata", dbg_rdata, 16'h0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b1;
    tick();

    // 1/2: write 0xBEEF to 0x0010, read back through MDR; WAIT=0 instance in parallel
    load_mar(16'h0010);
    load_mdr_bus(16'hBEEF);
    check("mdr_bus_load", mdr_out, 16'hBEEF);
    cpu_access(1'b1, lat, lat0, err);
    check("wr_latency", lat, 3);
    check("wr0_latency", lat0, 1);
    check("wr_err", err, 1'b0);
    tick();
    check("ready_one_pulse", mem_ready, 1'b0);
    load_mdr_bus(16'h0000);
    cpu_access(1'b0, lat, lat0, err);
    check("rd_latency", lat, 3);
    check("rd0_latency", lat0, 1);
    load_mdr_rdata();
    check("rd_data", mdr_out, 16'hBEEF);
    check("rd0_data", mdr_out0, 16'hBEEF);

    // 3: CPU read and debug write requested together; CPU first, ack 2 ticks after ready
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 12'h005; dbg_wdata = 16'h1234;
    cpu_access(1'b0, lat, lat0, err);
    check("prio_cpu_latency", lat, 3);
    check("prio_no_early_ack", dbg_ack, 1'b0);
    load_mdr_rdata();
    check("prio_cpu_data", mdr_out, 16'hBEEF);
    n = 1;
    while (!dbg_ack && n < 20) begin
      tick();
      n++;
    end
    dbg_req = 1'b0; dbg_we = 1'b0;
    check("prio_ack_delay", n, 2);
    dbg_access(1'b0, 12'h005, 16'h0, n);
    check("dbg_rd_ack", n, 2);
    check("dbg_rd_data", dbg_rdata, 16'h1234);
    load_mar(16'h0005);
    cpu_access(1'b0, lat, lat0, err);
    load_mdr_rdata();
    check("cpu_rd_dbg_data", mdr_out, 16'h1234);

    // 4: out-of-range write/read at 0x1000 must not alias M[0x000]
    dbg_access(1'b1, 12'h000, 16'h7777, n);
    load_mar(16'h1000);
    load_mdr_bus(16'hDEAD);
    cpu_access(1'b1, lat, lat0, err);
    check("oor_wr_err", err, 1'b1);
    check("oor_wr_latency", lat, 3);
    tick();
    check("oor_err_pulse", addr_err, 1'b0);
    cpu_access(1'b0, lat, lat0, err);
    check("oor_rd_err", err, 1'b1);
    load_mdr_rdata();
    check("oor_rd_data", mdr_out, 16'h0);
    dbg_access(1'b0, 12'h000, 16'h0, n);
    check("oor_no_alias", dbg_rdata, 16'h7777);

    // 5: reset during WAIT of a write to 0x0020
    dbg_access(1'b1, 12'h020, 16'h5555, n);
    load_mar(16'h0020);
    load_mdr_bus(16'h9999);
    mem_en = 1'b1; mem_we = 1'b1;
    tick();
    mem_en = 1'b0; mem_we = 1'b0;
    tick();
    check("pre_rst_busy", busy, 1'b1);
    reset = 1'b0;
    #2;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_mdr", mdr_out, 16'h0);
    #3;
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_ready) pulses++;
    end
    check("rst_no_ready", pulses, 0);
    dbg_access(1'b0, 12'h020, 16'h0, n);
    check("rst_no_write", dbg_rdata, 16'h5555);

    // 6: mem_en and ld_mar/ld_mdr during WAIT are ignored by the access in flight
    dbg_access(1'b1, 12'h031, 16'h0000, n);
    load_mar(16'h0030);
    load_mdr_bus(16'hCAFE);
    pulses = 0;
    mem_en = 1'b1; mem_we = 1'b1;
    tick();
    mem_en = 1'b0; mem_we = 1'b0;
    tick();
    mem_en = 1'b1; mem_we = 1'b1; bus_in = 16'h0031; ld_mar = 1'b1; ld_mdr = 1'b1;
    tick();
    mem_en = 1'b0; mem_we = 1'b0; ld_mar = 1'b0; ld_mdr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_ready) pulses++;
      tick();
    end
    check("busy_ignore_pulses", pulses, 1);
    dbg_access(1'b0, 12'h030, 16'h0, n);
    check("busy_ignore_orig_addr", dbg_rdata, 16'hCAFE);
    dbg_access(1'b0, 12'h031, 16'h0, n);
    check("busy_ignore_new_addr", dbg_rdata, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
